pal_field_padding_sequencer: RTL and testbench
==============================================

// Module: pal_field_padding_sequencer
// PURPOSE
// - Line/field sequencer for PAL Dragon video timing, clocked by nVCLK.
// - Generates the per-line timebase: a 229-count horizontal counter with a 17-count sync window.
// - Tracks VDG field sync (nFS) and freezes the VDG clock for two blocks of padding lines per field.
// - This stretches the 262-line VDG field to the 312-line PAL field.
// - Drives the VDG clock-gate enable and the padding/status flags used by the rest of the PAL logic.
// PARAMETERS
// LINE_LEN   229  nVCLK counts per line; hcount runs 0..LINE_LEN-1
// HS_LEN     17   hcount 0..HS_LEN-1 is the sync window (nHS low)
// PRE_LINES  8    lines from nFS fall to the start of the top pad
// PAD_LINES  25   lines per pad block (top and bottom identical)
// MID_LINES  254  run lines between the end of the top pad and the start of the bottom pad
// MAX_LINES  320  lines without an nFS fall before FsLost is flagged
// PORTS
// nVCLK      in   1  video clock; all flops update on its falling edge
// nRESET     in   1  asynchronous, active-low reset
// nFS        in   1  VDG field sync, asynchronous to nVCLK
// Enable     in   1  1 = padding sequencing active; 0 = VDG always clocked
// nHS        out  1  line sync, low while hcount < HS_LEN
// VdgClkEn   out  1  1 = VDG clock runs; 0 = VDG clock held (padding line)
// Pad        out  1  1 during any padding line
// FieldStart out  1  one-cycle pulse on the first cycle of PRE
// FsLost     out  1  sticky; cleared only by the next accepted nFS fall
// LineNum    out  9  lines since the last nFS fall, saturating at 511
// BEHAVIOUR
// - Reset values: hcount=0, nHS=0, VdgClkEn=1, Pad=0, FieldStart=0, FsLost=0, LineNum=0, state=WAIT_FS.
// - nFS synchroniser: two-flop synchroniser, then one edge-detect flop.
//   - A fall is detected 3 nVCLK cycles after the pin falls; call that cycle "fsfall".
// - Horizontal counter:
//   - hcount wraps LINE_LEN-1 -> 0; the wrap cycle is "eol".
//   - nHS is registered from hcount, so nHS is low exactly HS_LEN cycles per line.
// - Line counter (lcnt, 9 bits): increments on eol and clears on fsfall.
//   - LineNum = lcnt, saturating at 511.
//   - FsLost is set when lcnt reaches MAX_LINES.
// - FSM states: WAIT_FS, PRE, PAD_TOP, RUN, PAD_BOT.
//   - Each state has its own line counter, seg, which counts eol events.
// - Transitions:
//   - fsfall in any state: go to PRE, seg=0, pulse FieldStart.
//     - Resync is allowed mid-pad; VdgClkEn returns to 1 on the next cycle.
//   - PRE -> PAD_TOP on the eol at which seg reaches PRE_LINES.
//   - PAD_TOP -> RUN after PAD_LINES eol events.
//   - RUN -> PAD_BOT after MID_LINES eol events.
//   - PAD_BOT -> WAIT_FS after PAD_LINES eol events.
//   - WAIT_FS holds until fsfall. If lcnt reaches MAX_LINES there, FsLost is set and the state stays WAIT_FS.
// - Simultaneous fsfall and eol: fsfall wins and seg=0.
//   - lcnt=0, and the eol does not count toward PRE.
// - Pad state changes only on the eol cycle, so padding is always whole lines:
//   - Pad=1 exactly in PAD_TOP and PAD_BOT.
//   - VdgClkEn = ~Pad | ~Enable, registered.
// - Enable=0: the FSM still tracks (flags stay valid) but VdgClkEn=1.
//   - An Enable change affects VdgClkEn the next cycle, at any hcount.
// - Reset asserted mid-pad: VdgClkEn=1 immediately (asynchronous).
// - With defaults, pad lines per field = 50. A 262-line VDG field plus 50 = 312 PAL lines.
// STRUCTURE
// - Shared package:
//   - state encoding localparams (WAIT_FS=0, PRE=1, PAD_TOP=2, RUN=3, PAD_BOT=4);
//   - LINE_LEN, HS_LEN and the PAL line constants, reused by other PAL timing blocks.
// - One natural sub-module, pal_line_timebase:
//   - contains hcount, nHS and the eol strobe;
//   - parameters LINE_LEN and HS_LEN.
// - The FSM, the nFS synchroniser and the counters stay in the top level.
// TESTING
// - Reset, then free-run 3 lines:
//   - nHS low for 17 cycles every 229;
//   - VdgClkEn=1, Pad=0, state WAIT_FS.
// - nFS falls at hcount=100:
//   - FieldStart pulses 3 cycles later;
//   - Pad rises at the 8th eol;
//   - Pad stays high for exactly 25*229 cycles;
//   - VdgClkEn=0 throughout.
// - Full field with defaults:
//   - second pad starts 254 lines after the first ends;
//   - total Pad lines = 50;
//   - WAIT_FS entered at line 312.
// - nFS falls during PAD_TOP at line 10:
//   - next cycle after detection: Pad=0, VdgClkEn=1, LineNum=0;
//   - new pad begins 8 lines later.
// - nFS held high for 330 lines:
//   - FsLost=1 at line 320 and stays set;
//   - next nFS fall clears it and restarts PRE.
// - Enable=0 for a whole field:
//   - Pad follows the same pattern;
//   - VdgClkEn stays 1.
//   - Assert nRESET mid-PAD_BOT: outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pal_field_padding_sequencer_pkg.sv
// Shared PAL timing constants and sequencer state encoding.
// LINE_LEN/HS_LEN and the line counts are reused by other PAL timing blocks.
package pal_field_padding_sequencer_pkg;

    // Horizontal timebase, in nVCLK counts
    localparam int LINE_LEN  = 229;
    localparam int HS_LEN    = 17;

    // Field structure, in lines
    localparam int PRE_LINES = 8;
    localparam int PAD_LINES = 25;
    localparam int MID_LINES = 254;
    localparam int MAX_LINES = 320;

    // Counter widths
    localparam int LCNT_W    = 9;
    localparam int SEG_W     = 9;

    typedef enum logic [2:0] {
        WAIT_FS = 3'd0,
        PRE     = 3'd1,
        PAD_TOP = 3'd2,
        RUN     = 3'd3,
        PAD_BOT = 3'd4
    } seq_state_t;

    // True for the two states in which the VDG clock is frozen
    function automatic logic state_is_pad(input seq_state_t s);
        return (s == PAD_TOP) || (s == PAD_BOT);
    endfunction

    // Value of the per-state line counter on the last line of that state
    function automatic logic [SEG_W-1:0] seg_last(input seq_state_t s);
        logic [SEG_W-1:0] v;
        case (s)
            PRE:     v = SEG_W'(PRE_LINES - 1);
            PAD_TOP: v = SEG_W'(PAD_LINES - 1);
            RUN:     v = SEG_W'(MID_LINES - 1);
            PAD_BOT: v = SEG_W'(PAD_LINES - 1);
            default: v = '1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pal_field_padding_sequencer_line_timebase.sv
// Per-line timebase: free-running horizontal counter, registered line sync
// and the end-of-line strobe. Flops update on the falling edge of clk.
module pal_line_timebase #(
    parameter int LINE_LEN = 229,
    parameter int HS_LEN   = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic hs_n,
    output logic eol
);

    localparam int HW = $clog2(LINE_LEN);
    localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HS_LEN);

    logic [HW-1:0] hcount;
    logic [HW-1:0] hcount_nx;

    // eol marks the last count of the line; the counter wraps on the next edge
    always_comb begin
        eol       = (hcount == H_LAST);
        hcount_nx = eol ? '0 : hcount + 1'b1;
    end

    // hs_n is derived from the next count so it stays aligned with hcount
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            hs_n   <= 1'b0;
        end else begin
            hcount <= hcount_nx;
            hs_n   <= (hcount_nx >= H_SYNC_END);
        end
    end

endmodule

// File: rtl/pal_field_padding_sequencer.sv
// PAL Dragon line/field sequencer. Tracks VDG field sync and freezes the VDG
// clock for two blocks of whole padding lines per field, stretching the
// 262-line VDG field to the 312-line PAL field. All flops use the falling
// edge of nVCLK.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   WAIT_FS | idle after a field (or from reset); waits for an nFS fall
//   PRE     | lines between the nFS fall and the top pad
//   PAD_TOP | top padding block, VDG clock held when Enable=1
//   RUN     | VDG clocked between the two pads
//   PAD_BOT | bottom padding block, VDG clock held when Enable=1
module pal_field_padding_sequencer
    import pal_field_padding_sequencer_pkg::*;
(
    input  logic       nVCLK,
    input  logic       nRESET,
    input  logic       nFS,
    input  logic       Enable,
    output logic       nHS,
    output logic       VdgClkEn,
    output logic       Pad,
    output logic       FieldStart,
    output logic       FsLost,
    output logic [8:0] LineNum
);

    localparam logic [LCNT_W-1:0] LCNT_MAX  = '1;
    localparam logic [LCNT_W-1:0] LOST_PREV = LCNT_W'(MAX_LINES - 1);

    logic              eol;
    logic              fs_meta;
    logic              fs_sync;
    logic              fs_prev;
    logic              fs_fall;
    logic [LCNT_W-1:0] lcnt;
    seq_state_t        state;
    seq_state_t        state_nx;
    logic [SEG_W-1:0]  seg;
    logic [SEG_W-1:0]  seg_nx;

    pal_line_timebase #(
        .LINE_LEN (LINE_LEN),
        .HS_LEN   (HS_LEN)
    ) u_timebase (
        .clk   (nVCLK),
        .rst_n (nRESET),
        .hs_n  (nHS),
        .eol   (eol)
    );

    // Two-flop synchroniser plus edge-detect flop; idle level of nFS is high
    always_ff @(negedge nVCLK or negedge nRESET) begin
        if (!nRESET) begin
            fs_meta <= 1'b1;
            fs_sync <= 1'b1;
            fs_prev <= 1'b1;
        end else begin
            fs_meta <= nFS;
            fs_sync <= fs_meta;
            fs_prev <= fs_sync;
        end
    end

    assign fs_fall = fs_prev & ~fs_sync;

    // Lines since the last accepted nFS fall; a fall beats a coincident eol
    always_ff @(negedge nVCLK or negedge nRESET) begin
        if (!nRESET) begin
            lcnt <= '0;
        end else if (fs_fall) begin
            lcnt <= '0;
        end else if (eol && (lcnt != LCNT_MAX)) begin
            lcnt <= lcnt + 1'b1;
        end
    end

    assign LineNum = lcnt;

    // Sticky loss-of-sync flag, set as lcnt steps onto MAX_LINES
    always_ff @(negedge nVCLK or negedge nRESET) begin
        if (!nRESET) begin
            FsLost <= 1'b0;
        end else if (fs_fall) begin
            FsLost <= 1'b0;
        end else if (eol && (lcnt == LOST_PREV)) begin
            FsLost <= 1'b1;
        end
    end

    // Next state: only an nFS fall or an eol can move the sequencer, so pads
    // always start and end on line boundaries unless a resync cuts one short
    always_comb begin
        state_nx = state;
        seg_nx   = seg;
        if (fs_fall) begin
            state_nx = PRE;
            seg_nx   = '0;
        end else if (eol && (state != WAIT_FS)) begin
            if (seg == seg_last(state)) begin
                seg_nx = '0;
                case (state)
                    PRE:     state_nx = PAD_TOP;
                    PAD_TOP: state_nx = RUN;
                    RUN:     state_nx = PAD_BOT;
                    default: state_nx = WAIT_FS;
                endcase
            end else begin
                seg_nx = seg + 1'b1;
            end
        end
    end

    // Sequencer registers and registered outputs
    always_ff @(negedge nVCLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= WAIT_FS;
            seg        <= '0;
            Pad        <= 1'b0;
            VdgClkEn   <= 1'b1;
            FieldStart <= 1'b0;
        end else begin
            state      <= state_nx;
            seg        <= seg_nx;
            Pad        <= state_is_pad(state_nx);
            VdgClkEn   <= ~state_is_pad(state_nx) | ~Enable;
            FieldStart <= fs_fall;
        end
    end

endmodule

// File: tb/tb_pal_field_padding_sequencer.sv
// Self-checking bench for pal_field_padding_sequencer. A line-level reference
// model (lines since the last nFS fall -> expected pad/flags) is compared
// against the DUT every cycle, plus directed checks at the key boundaries.
module tb_pal_field_padding_sequencer;

    localparam int LL        = 229;
    localparam int HSL       = 17;
    localparam int PRE_L     = 8;
    localparam int PAD_L     = 25;
    localparam int MID_L     = 254;
    localparam int MAX_L     = 320;
    localparam int TOP_START = PRE_L;
    localparam int TOP_END   = PRE_L + PAD_L;
    localparam int BOT_START = TOP_END + MID_L;
    localparam int BOT_END   = BOT_START + PAD_L;

    logic       nVCLK  = 1'b1;
    logic       nRESET = 1'b0;
    logic       nFS    = 1'b1;
    logic       Enable = 1'b1;
    logic       nHS;
    logic       VdgClkEn;
    logic       Pad;
    logic       FieldStart;
    logic       FsLost;
    logic [8:0] LineNum;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_k      = 0;
    int m_line   = 0;
    bit m_synced = 1'b0;
    bit m_h1     = 1'b1;
    bit m_h2     = 1'b1;
    bit m_h3     = 1'b1;
    bit e_nhs    = 1'b0;
    bit e_vdg    = 1'b1;
    bit e_pad    = 1'b0;
    bit e_fs     = 1'b0;
    bit e_lost   = 1'b0;
    int e_line   = 0;

    // bench-side measurements
    int hs_low     = 0;
    int pad_cycles = 0;
    bit pad_prev   = 1'b0;
    int rises[$];
    int falls[$];
    int fall_lines[$];

    pal_field_padding_sequencer dut (
        .nVCLK      (nVCLK),
        .nRESET     (nRESET),
        .nFS        (nFS),
        .Enable     (Enable),
        .nHS        (nHS),
        .VdgClkEn   (VdgClkEn),
        .Pad        (Pad),
        .FieldStart (FieldStart),
        .FsLost     (FsLost),
        .LineNum    (LineNum)
    );

    always #5 nVCLK = ~nVCLK;

    function automatic bit pad_line(input int l, input bit synced);
        return synced && (((l >= TOP_START) && (l < TOP_END)) ||
                          ((l >= BOT_START) && (l < BOT_END)));
    endfunction

    // Reference model: nFS fall takes effect 3 edges after the pin falls;
    // everything else follows from lines counted since that fall.
    always @(negedge nVCLK or negedge nRESET) begin
        if (!nRESET) begin
            m_k      = 0;
            m_line   = 0;
            m_synced = 1'b0;
            m_h1     = 1'b1;
            m_h2     = 1'b1;
            m_h3     = 1'b1;
            e_nhs    = 1'b0;
            e_vdg    = 1'b1;
            e_pad    = 1'b0;
            e_fs     = 1'b0;
            e_lost   = 1'b0;
            e_line   = 0;
        end else begin
            bit eol_edge;
            bit fall_edge;
            eol_edge  = ((m_k % LL) == LL - 1);
            fall_edge = m_h3 && !m_h2;
            m_h3 = m_h2;
            m_h2 = m_h1;
            m_h1 = nFS;
            m_k++;
            if (fall_edge) begin
                m_line   = 0;
                m_synced = 1'b1;
            end else if (eol_edge && (m_line < 511)) begin
                m_line++;
            end
            e_fs   = fall_edge;
            e_pad  = pad_line(m_line, m_synced);
            e_vdg  = !e_pad || !Enable;
            e_lost = (m_line >= MAX_L);
            e_line = m_line;
            e_nhs  = ((m_k % LL) >= HSL);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("nHS",        nHS,        e_nhs);
        check("VdgClkEn",   VdgClkEn,   e_vdg);
        check("Pad",        Pad,        e_pad);
        check("FieldStart", FieldStart, e_fs);
        check("FsLost",     FsLost,     e_lost);
        check("LineNum",    LineNum,    e_line);
    endtask

    task automatic tick();
        @(posedge nVCLK);
        check_all();
        if (nHS === 1'b0) hs_low++;
        if (Pad === 1'b1) pad_cycles++;
        if ((Pad === 1'b1) && !pad_prev) rises.push_back(m_k);
        if ((Pad === 1'b0) && pad_prev) begin
            falls.push_back(m_k);
            fall_lines.push_back(int'(LineNum));
        end
        pad_prev = (Pad === 1'b1);
    endtask

    task automatic run_until_line(input int target, input int budget, input bit rand_en);
        int n = 0;
        while ((m_line != target) && (n < budget)) begin
            if (rand_en && ($urandom_range(0, 299) == 0)) Enable = ~Enable;
            tick();
            n++;
        end
        if (m_line != target) begin
            miscompares++;
            $error("FAIL timeout_line observed=%0d expected=%0d", m_line, target);
        end
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int n = 0;
        while (((m_k % LL) != ph) && (n < budget)) begin
            tick();
            n++;
        end
        if ((m_k % LL) != ph) begin
            miscompares++;
            $error("FAIL timeout_phase observed=%0d expected=%0d", m_k % LL, ph);
        end
    endtask

    initial begin
        // reset held, then free-run three lines with no field sync
        repeat (3) tick();
        nRESET = 1'b1;
        hs_low = 0;
        pad_cycles = 0;
        repeat (3 * LL) tick();
        check("hs_low_3lines", hs_low, 3 * HSL);
        check("pad_idle", pad_cycles, 0);

        // field 1: nFS falls at hcount=100, run past FsLost threshold
        wait_phase(100, 2 * LL);
        nFS = 1'b0;
        pad_cycles = 0;
        rises.delete();
        falls.delete();
        fall_lines.delete();
        repeat (3) tick();
        check("fieldstart_3cyc", FieldStart, 1);
        repeat (LL) tick();
        nFS = 1'b1;
        run_until_line(200, 250 * LL, 1'b0);
        Enable = 1'b0;
        run_until_line(MAX_L + 2, 130 * LL, 1'b0);
        check("fslost_set", FsLost, 1);
        check("pad_total", pad_cycles, 2 * PAD_L * LL);
        check("pad_blocks", rises.size(), 2);
        if ((rises.size() >= 2) && (falls.size() >= 2)) begin
            check("top_pad_len", falls[0] - rises[0], PAD_L * LL);
            check("bot_pad_len", falls[1] - rises[1], PAD_L * LL);
            check("mid_gap",     rises[1] - falls[0], MID_L * LL);
            check("top_end_line", fall_lines[0], TOP_END);
            check("wait_fs_line", fall_lines[1], BOT_END);
        end
        Enable = 1'b1;

        // field 2: detection coincides with eol, lcnt must clear
        wait_phase(LL - 3, 2 * LL);
        nFS = 1'b0;
        repeat (3) tick();
        check("fs_on_eol_start", FieldStart, 1);
        check("fs_on_eol_line",  LineNum, 0);
        check("fslost_cleared",  FsLost, 0);
        repeat (20) tick();
        nFS = 1'b1;

        // resync during the top pad at line 10
        run_until_line(10, 12 * LL, 1'b0);
        repeat ($urandom_range(20, 200)) tick();
        check("vdg_held_in_pad", VdgClkEn, 0);
        nFS = 1'b0;
        repeat (3) tick();
        check("resync_pad",  Pad, 0);
        check("resync_vdg",  VdgClkEn, 1);
        check("resync_line", LineNum, 0);
        repeat (10) tick();
        nFS = 1'b1;
        run_until_line(PRE_L, 9 * LL, 1'b1);
        Enable = 1'b1;
        tick();
        check("repad_after_8", Pad, 1);

        // asynchronous reset in the middle of a pad line
        run_until_line(12, 5 * LL, 1'b0);
        repeat ($urandom_range(1, LL - 1)) tick();
        check("pre_reset_vdg", VdgClkEn, 0);
        #2 nRESET = 1'b0;
        #1;
        check("async_vdg",  VdgClkEn, 1);
        check("async_pad",  Pad, 0);
        check("async_nhs",  nHS, 0);
        check("async_line", LineNum, 0);
        check_all();
        repeat (3) tick();
        nRESET = 1'b1;
        repeat (LL) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
